block_feeder_4x32: RTL and testbench

Operand buffer and skew generator on the transmit side of the 4x32 block-multiply engine. It loads a 4x32 A tile and a 32x4 B tile through a word-write port. On start, it drives the eight north/west lane buses with correctly skewed 4x4 sub-tiles and sequences the engine's reset so the engine's compute window aligns with slot 0. It then waits for the engine's done and reports completion or timeout to the host controller.

---
 rtl/block_feeder_4x32.sv | 159 +++++++++++++++
 tb/tb_block_feeder_4x32.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_feeder_4x32.sv
// rtl/block_feeder_4x32.sv - operand buffer and skew generator for the 4x32 block-multiply engine
// Lanes and engine reset are registered from next-state so they line up with slot t.
module block_feeder_4x32 #(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int TIMEOUT    = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [6:0]             wr_addr,
  input  logic [BIT_WIDTH-1:0]   wr_data,
  input  logic                   start,
  input  logic                   blk_done,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   blk_rst_n,
  output logic [4*BIT_WIDTH-1:0] north_out0,
  output logic [4*BIT_WIDTH-1:0] north_out1,
  output logic [4*BIT_WIDTH-1:0] north_out2,
  output logic [4*BIT_WIDTH-1:0] north_out3,
  output logic [4*BIT_WIDTH-1:0] north_out4,
  output logic [4*BIT_WIDTH-1:0] north_out5,
  output logic [4*BIT_WIDTH-1:0] north_out6,
  output logic [4*BIT_WIDTH-1:0] north_out7,
  output logic [4*BIT_WIDTH-1:0] west_out0,
  output logic [4*BIT_WIDTH-1:0] west_out1,
  output logic [4*BIT_WIDTH-1:0] west_out2,
  output logic [4*BIT_WIDTH-1:0] west_out3,
  output logic [4*BIT_WIDTH-1:0] west_out4,
  output logic [4*BIT_WIDTH-1:0] west_out5,
  output logic [4*BIT_WIDTH-1:0] west_out6,
  output logic [4*BIT_WIDTH-1:0] west_out7
);

  localparam int LW = 4 * BIT_WIDTH;
  localparam int CW = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [CW-1:0] LAST_SLOT = CW'(15);
  localparam logic [CW-1:0] TO_CNT    = CW'(TIMEOUT);

  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= BIT_WIDTH) begin : g_frac_check
    $error("FRAC_WIDTH must lie in 0..BIT_WIDTH-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           blk_rst_n_q, blk_rst_n_d;
  logic [LW-1:0]  west_q [8];
  logic [LW-1:0]  west_d [8];
  logic [LW-1:0]  north_q [8];
  logic [LW-1:0]  north_d [8];
  logic [BIT_WIDTH-1:0] a_mem [128];
  logic [BIT_WIDTH-1:0] b_mem [128];
  int             slot;

  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE) begin
      if (wr_sel) b_mem[wr_addr] <= wr_data;
      else        a_mem[wr_addr] <= wr_data;
    end
  end

  // cnt counts cycles since STREAM entry; its low nibble is the slot t while streaming
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_SLOT) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (blk_done) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TO_CNT) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    blk_rst_n_d = (state_d == S_STREAM) || (state_d == S_WAIT);
  end

  // Row/column s of lane i is delayed by s slots; beyond slot 6 everything is zero
  always_comb begin
    slot = int'(cnt_d[3:0]);
    for (int i = 0; i < 8; i++) begin
      west_d[i]  = '0;
      north_d[i] = '0;
    end
    if (state_d == S_STREAM) begin
      for (int i = 0; i < 8; i++) begin
        for (int s = 0; s < 4; s++) begin
          if (slot >= s && slot <= s + 3) begin
            west_d[i][(3-s)*BIT_WIDTH +: BIT_WIDTH]  = a_mem[7'(s*32 + 4*i + slot - s)];
            north_d[i][(3-s)*BIT_WIDTH +: BIT_WIDTH] = b_mem[7'((4*i + slot - s)*4 + s)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      blk_rst_n_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        west_q[i]  <= '0;
        north_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_rst_n_q <= blk_rst_n_d;
      for (int i = 0; i < 8; i++) begin
        west_q[i]  <= west_d[i];
        north_q[i] <= north_d[i];
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign blk_rst_n  = blk_rst_n_q;
  assign west_out0  = west_q[0];
  assign west_out1  = west_q[1];
  assign west_out2  = west_q[2];
  assign west_out3  = west_q[3];
  assign west_out4  = west_q[4];
  assign west_out5  = west_q[5];
  assign west_out6  = west_q[6];
  assign west_out7  = west_q[7];
  assign north_out0 = north_q[0];
  assign north_out1 = north_q[1];
  assign north_out2 = north_q[2];
  assign north_out3 = north_q[3];
  assign north_out4 = north_q[4];
  assign north_out5 = north_q[5];
  assign north_out6 = north_q[6];
  assign north_out7 = north_q[7];

endmodule

// File: tb/tb_block_feeder_4x32.sv
// tb/tb_block_feeder_4x32.sv - self-checking bench for block_feeder_4x32
// Timeline model of one tile run plus hand-computed slot literals.
module tb_block_feeder_4x32;

  localparam int BW = 16;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst, wr_en, wr_sel, start, blk_done;
  logic [6:0]  wr_addr;
  logic [BW-1:0] wr_data;
  logic busy, done, timeout, blk_rst_n;
  logic [4*BW-1:0] north_out0, north_out1, north_out2, north_out3;
  logic [4*BW-1:0] north_out4, north_out5, north_out6, north_out7;
  logic [4*BW-1:0] west_out0, west_out1, west_out2, west_out3;
  logic [4*BW-1:0] west_out4, west_out5, west_out6, west_out7;
  logic [4*BW-1:0] nw [8];
  logic [4*BW-1:0] ww [8];

  block_feeder_4x32 #(.BIT_WIDTH(BW), .FRAC_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .blk_done(blk_done), .busy(busy),
    .done(done), .timeout(timeout), .blk_rst_n(blk_rst_n),
    .north_out0(north_out0), .north_out1(north_out1), .north_out2(north_out2),
    .north_out3(north_out3), .north_out4(north_out4), .north_out5(north_out5),
    .north_out6(north_out6), .north_out7(north_out7),
    .west_out0(west_out0), .west_out1(west_out1), .west_out2(west_out2),
    .west_out3(west_out3), .west_out4(west_out4), .west_out5(west_out5),
    .west_out6(west_out6), .west_out7(west_out7)
  );

  assign nw[0] = north_out0; assign nw[1] = north_out1;
  assign nw[2] = north_out2; assign nw[3] = north_out3;
  assign nw[4] = north_out4; assign nw[5] = north_out5;
  assign nw[6] = north_out6; assign nw[7] = north_out7;
  assign ww[0] = west_out0;  assign ww[1] = west_out1;
  assign ww[2] = west_out2;  assign ww[3] = west_out3;
  assign ww[4] = west_out4;  assign ww[5] = west_out5;
  assign ww[6] = west_out6;  assign ww[7] = west_out7;

  initial forever #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // model state: the A/B tiles and the position in the run (m_e = cycles since STREAM entry, -1 in ARM)
  logic [BW-1:0] ma [4][32];
  logic [BW-1:0] mb [32][4];
  bit  m_run = 0;
  int  m_e = 0;

  int done_cnt, to_cnt, busy_cnt, done_e, to_e;
  logic [63:0] snap_w [16][8];
  logic [63:0] snap_n [16][8];

  function automatic logic [63:0] exp_west(int i, int t);
    logic [63:0] v = '0;
    for (int r = 0; r < 4; r++)
      if (t - r >= 0 && t - r <= 3) v[(3-r)*BW +: BW] = ma[r][4*i + t - r];
    return v;
  endfunction

  function automatic logic [63:0] exp_north(int i, int t);
    logic [63:0] v = '0;
    for (int c = 0; c < 4; c++)
      if (t - c >= 0 && t - c <= 3) v[(3-c)*BW +: BW] = mb[4*i + t - c][c];
    return v;
  endfunction

  always @(negedge clk) begin
    bit streaming, wait_ph, e_done, e_to;
    if (rst) m_run = 0;
    streaming = m_run && m_e >= 0 && m_e < 16;
    wait_ph   = m_run && m_e >= 16;
    e_done    = wait_ph && blk_done;
    e_to      = wait_ph && !blk_done && m_e == TO;
    chk($sformatf("busy_e%0d", m_e), 64'(busy), 64'(m_run));
    chk($sformatf("blk_rst_n_e%0d", m_e), 64'(blk_rst_n), 64'(m_run && m_e >= 0));
    chk($sformatf("done_e%0d", m_e), 64'(done), 64'(e_done));
    chk($sformatf("timeout_e%0d", m_e), 64'(timeout), 64'(e_to));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("west%0d_e%0d", i, m_e), ww[i], streaming ? exp_west(i, m_e) : 64'h0);
      chk($sformatf("north%0d_e%0d", i, m_e), nw[i], streaming ? exp_north(i, m_e) : 64'h0);
    end
    if (streaming)
      for (int i = 0; i < 8; i++) begin
        snap_w[m_e][i] = ww[i];
        snap_n[m_e][i] = nw[i];
      end
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_e = m_e; end
    if (timeout) begin to_cnt++; to_e = m_e; end
    if (!rst) begin
      if (!m_run) begin
        if (wr_en) begin
          if (wr_sel) mb[wr_addr[6:2]][wr_addr[1:0]] = wr_data;
          else        ma[wr_addr[6:5]][wr_addr[4:0]] = wr_data;
        end
        if (start) begin m_run = 1; m_e = -1; end
      end else if (e_done || e_to) begin
        m_run = 0;
      end else begin
        m_e++;
      end
    end
  end

  task automatic clr_stats();
    done_cnt = 0; to_cnt = 0; busy_cnt = 0; done_e = -1; to_e = -1;
  endtask

  task automatic wr(bit sel, int addr, logic [BW-1:0] d);
    wr_en = 1; wr_sel = sel; wr_addr = 7'(addr); wr_data = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic load_zero();
    for (int a = 0; a < 128; a++) begin
      wr(1'b0, a, '0);
      wr(1'b1, a, '0);
    end
  endtask

  task automatic load_pat();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 32; k++) wr(1'b0, r*32 + k, 16'(r*256 + k + 1));
    for (int k = 0; k < 32; k++)
      for (int c = 0; c < 4; c++) wr(1'b1, k*4 + c, 16'h8000 | 16'(k*4 + c));
  endtask

  // done_at < 0: engine never answers; otherwise blk_done held from elapsed cycle done_at
  task automatic run_tile(int done_at, bit guard);
    int k;
    clr_stats();
    start = 1;
    @(posedge clk); #1;
    start = guard;
    k = 1;
    while (busy && k < 100) begin
      blk_done = (done_at >= 0) && (k - 2 >= done_at);
      if (guard) begin
        wr_en = 1; wr_sel = 1'($urandom_range(0, 1));
        wr_addr = 7'($urandom_range(0, 127)); wr_data = 16'hDEAD ^ 16'(k);
      end
      @(posedge clk); #1;
      k++;
    end
    start = 0; wr_en = 0; blk_done = 0;
    chk("run_bound", 64'(k < 100), 64'(1));
    chk("rst_n_after_run", 64'(blk_rst_n), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0; start = 0; blk_done = 0;
    clr_stats();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_rst_n", 64'(blk_rst_n), 64'(0));
    chk("reset_west0", west_out0, 64'h0);

    load_zero();
    wr(1'b0, 2*32 + 5, 16'h0300);
    run_tile(23, 0);
    chk("skewA_t3", snap_w[3][1], 64'h0000_0000_0300_0000);
    chk("skewA_t2", snap_w[2][1], 64'h0);
    chk("skewA_t4", snap_w[4][1], 64'h0);
    chk("hs_done_cnt", 64'(done_cnt), 64'(1));
    chk("hs_done_e", 64'(done_e), 64'(23));
    chk("hs_to_cnt", 64'(to_cnt), 64'(0));
    chk("hs_busy_cycles", 64'(busy_cnt), 64'(25));

    load_zero();
    wr(1'b1, 9*4 + 3, 16'h0500);
    run_tile(23, 0);
    chk("skewB_t4", snap_n[4][2], 64'h0000_0000_0000_0500);
    chk("skewB_t3", snap_n[3][2], 64'h0);
    chk("skewB_t10", snap_n[10][2], 64'h0);

    load_pat();
    run_tile(23, 0);
    chk("pat_west0_t3", snap_w[3][0], 64'h0004_0103_0202_0301);
    chk("pat_north7_t6", snap_n[6][7], 64'h0000_0000_0000_807F);
    chk("pat_north0_t0", snap_n[0][0], 64'h8000_0000_0000_0000);

    run_tile(23, 1);
    chk("guard_west0_t3", snap_w[3][0], 64'h0004_0103_0202_0301);
    chk("guard_north7_t6", snap_n[6][7], 64'h0000_0000_0000_807F);
    chk("guard_done_cnt", 64'(done_cnt), 64'(1));
    chk("guard_busy_cycles", 64'(busy_cnt), 64'(25));

    run_tile(-1, 0);
    chk("to_cnt", 64'(to_cnt), 64'(1));
    chk("to_e", 64'(to_e), 64'(40));
    chk("to_done_cnt", 64'(done_cnt), 64'(0));
    chk("to_busy_cycles", 64'(busy_cnt), 64'(42));

    run_tile(23, 0);
    chk("after_to_done_e", 64'(done_e), 64'(23));

    run_tile(40, 0);
    chk("coinc_done_cnt", 64'(done_cnt), 64'(1));
    chk("coinc_to_cnt", 64'(to_cnt), 64'(0));
    chk("coinc_done_e", 64'(done_e), 64'(40));

    run_tile(5, 0);
    chk("early_done_e", 64'(done_e), 64'(16));
    chk("early_busy_cycles", 64'(busy_cnt), 64'(18));

    clr_stats();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_rst_n", 64'(blk_rst_n), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("midrst_west%0d", i), ww[i], 64'h0);
      chk($sformatf("midrst_north%0d", i), nw[i], 64'h0);
    end
    @(posedge clk); #1 rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt + to_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
